// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
//   Serial receive front end: synchronises the rxd pin, deserialises 8N1 UART
//   frames (LSB first) and buffers completed bytes in a small circular FIFO
//   that the consumer drains over a valid/ready handshake.
//
// Ports
//   clk        system clock
//   rst        synchronous reset, active-high
//   rxd        asynchronous serial input, idle high
//   rdata      byte at the FIFO head (valid only while rvalid=1, else 0)
//   rvalid     FIFO non-empty
//   rready     consumer accepts rdata this cycle
//   count      number of stored bytes (0 .. 2**FIFO_AW)
//   overrun    one-cycle pulse: completed byte dropped because FIFO was full
//   frame_err  one-cycle pulse: stop bit sampled low, byte discarded
module uart_rx_fifo #(
  parameter int CLK_PER_BIT = 868,
  parameter int FIFO_AW     = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rxd,
  output logic [7:0]         rdata,
  output logic               rvalid,
  input  logic               rready,
  output logic [FIFO_AW:0]   count,
  output logic               overrun,
  output logic               frame_err
);

  localparam int CW    = $clog2(CLK_PER_BIT);
  localparam int DEPTH = 1 << FIFO_AW;

  localparam logic [CW-1:0]    CNT_LAST = CW'(CLK_PER_BIT - 1);
  localparam logic [CW-1:0]    CNT_HALF = CW'(CLK_PER_BIT / 2 - 1);
  localparam logic [FIFO_AW:0] DEPTH_C  = (FIFO_AW + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  // Input synchroniser
  logic sync1_q;
  logic rxd_s_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      rxd_s_q <= 1'b1;
    end else begin
      sync1_q <= rxd;
      rxd_s_q <= sync1_q;
    end
  end

  // Frame FSM
  state_t        state_q;
  logic [CW-1:0] clk_cnt_q;
  logic [2:0]    bit_idx_q;
  logic [7:0]    shift_q;
  logic          armed_q;
  logic          frame_err_q;

  // armed_q blocks a new start after a low stop bit until the line has been
  // seen high again, so a held-low line never produces a spurious frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      clk_cnt_q   <= '0;
      bit_idx_q   <= '0;
      armed_q     <= 1'b1;
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (rxd_s_q) armed_q <= 1'b1;
          if (!rxd_s_q && armed_q) begin
            state_q   <= START;
            clk_cnt_q <= '0;
          end
        end
        START: begin
          if (clk_cnt_q == CNT_HALF) begin
            clk_cnt_q <= '0;
            bit_idx_q <= '0;
            state_q   <= rxd_s_q ? IDLE : DATA;
          end else begin
            clk_cnt_q <= clk_cnt_q + CW'(1);
          end
        end
        DATA: begin
          if (clk_cnt_q == CNT_LAST) begin
            clk_cnt_q          <= '0;
            shift_q[bit_idx_q] <= rxd_s_q;
            if (bit_idx_q == 3'd7) state_q   <= STOP;
            else                   bit_idx_q <= bit_idx_q + 3'd1;
          end else begin
            clk_cnt_q <= clk_cnt_q + CW'(1);
          end
        end
        STOP: begin
          if (clk_cnt_q == CNT_LAST) begin
            clk_cnt_q <= '0;
            state_q   <= IDLE;
            if (!rxd_s_q) begin
              frame_err_q <= 1'b1;
              armed_q     <= 1'b0;
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + CW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Byte completion: decoded from the stop-bit sample cycle
  logic push;
  assign push = (state_q == STOP) && (clk_cnt_q == CNT_LAST) && rxd_s_q;

  // FIFO storage and pointers
  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wptr_q;
  logic [FIFO_AW-1:0] rptr_q;
  logic [FIFO_AW:0]   count_q;
  logic [FIFO_AW:0]   count_d;
  logic               overrun_q;
  logic               pop;
  logic               full;
  logic               wr_en;

  assign rvalid = (count_q != '0);
  assign pop    = rvalid && rready;
  assign full   = (count_q == DEPTH_C);
  // A pop in the same cycle frees the slot the push lands in.
  assign wr_en  = push && (!full || pop);

  always_comb begin
    count_d = count_q;
    if (wr_en && !pop)      count_d = count_q + (FIFO_AW + 1)'(1);
    else if (!wr_en && pop) count_d = count_q - (FIFO_AW + 1)'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= push && full && !pop;
      if (wr_en) wptr_q <= wptr_q + FIFO_AW'(1);
      if (pop)   rptr_q <= rptr_q + FIFO_AW'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !rst) mem[wptr_q] <= shift_q;
  end

  // Head entry only changes on a pop, so rdata is stable while stalled.
  assign rdata     = rvalid ? mem[rptr_q] : 8'h00;
  assign count     = count_q;
  assign overrun   = overrun_q;
  assign frame_err = frame_err_q;

endmodule
